// File: rtl/coax_pkg.sv
// Shared coax definitions: word width and TX feeder state encodings.
package coax_pkg;

    localparam int COAX_WORD_WIDTH = 10;

    typedef logic [COAX_WORD_WIDTH-1:0] coax_word_t;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ARM      = 3'd1;
    localparam logic [2:0] SEND     = 3'd2;
    localparam logic [2:0] WAIT_ACK = 3'd3;
    localparam logic [2:0] FLUSH    = 3'd4;

endpackage

// File: rtl/coax_fifo.sv
// Parameterised synchronous FIFO with a registered read port.
// Used by the coax TX feeder; intended for reuse on the RX path.
module coax_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 10,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign level = wptr - rptr;
    assign empty = (wptr == rptr);
    // Extra pointer MSB separates a full ring from an empty one.
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr    <= '0;
            rptr    <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + PTR_ONE;
            end
            if (do_rd) begin
                rptr    <= rptr + PTR_ONE;
                rd_data <= mem[rptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/coax_tx_feeder.sv
// Buffers host coax words and meters committed frames into coax_tx.
// Define COAX_TX_FEEDER_STATS_EN to add frame_words/frame_count.
module coax_tx_feeder
    import coax_pkg::*;
#(
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [COAX_WORD_WIDTH-1:0] wr_data,
    input  logic                       wr_strobe,
    input  logic                       start,
    input  logic                       clear_error,
    output logic                       full,
    output logic                       empty,
    output logic [ADDR_WIDTH:0]        level,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic [COAX_WORD_WIDTH-1:0] tx_data,
    output logic                       tx_strobe,
    input  logic                       tx_ready,
    input  logic                       tx_active
`ifdef COAX_TX_FEEDER_STATS_EN
    ,
    output logic [15:0]                frame_words,
    output logic [15:0]                frame_count
`endif
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       pop;
    logic       done_nxt;

    coax_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (COAX_WORD_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_strobe),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (tx_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // Next word is fetched only once coax_tx has dropped ready.
    assign pop = (state == ARM) ||
                 ((state == WAIT_ACK) && !tx_ready && !empty);

    assign tx_strobe = (state == SEND) && tx_ready;
    assign done_nxt  = (state == FLUSH) && !tx_active;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start && !empty) state_nxt = ARM;
            ARM:      state_nxt = SEND;
            SEND:     if (tx_ready) state_nxt = WAIT_ACK;
            WAIT_ACK: if (!tx_ready) state_nxt = empty ? FLUSH : SEND;
            FLUSH:    if (!tx_active) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (wr_strobe && full) begin
                overflow <= 1'b1;
            end else if (clear_error) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef COAX_TX_FEEDER_STATS_EN
    logic [15:0] words_cur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            words_cur   <= '0;
            frame_words <= '0;
            frame_count <= '0;
        end else begin
            if (state == IDLE) begin
                words_cur <= '0;
            end else if (pop) begin
                words_cur <= words_cur + 16'd1;
            end
            if (done_nxt) begin
                frame_words <= words_cur;
                frame_count <= frame_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_coax_tx_feeder.sv
// Self-checking bench for coax_tx_feeder with a coax_tx responder model.
// Stats checks run when COAX_TX_FEEDER_STATS_EN is defined.
module tb_coax_tx_feeder;
    import coax_pkg::*;

    localparam int DEPTH    = 4;
    localparam int WORD_CYC = 3;
    localparam int TAIL     = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] wr_data = '0;
    logic       wr_strobe = 1'b0;
    logic       start = 1'b0;
    logic       clear_error = 1'b0;
    logic       full, empty, busy, done, overflow, tx_strobe;
    logic [2:0] level;
    logic [9:0] tx_data;
    logic       tx_ready;
    logic       tx_active = 1'b0;
    logic       rsp_ready = 1'b1;
    logic       ready_block = 1'b0;
`ifdef COAX_TX_FEEDER_STATS_EN
    logic [15:0] frame_words, frame_count;
`endif

    assign tx_ready = rsp_ready & ~ready_block;

    coax_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_data     (wr_data),
        .wr_strobe   (wr_strobe),
        .start       (start),
        .clear_error (clear_error),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .tx_data     (tx_data),
        .tx_strobe   (tx_strobe),
        .tx_ready    (tx_ready),
        .tx_active   (tx_active)
`ifdef COAX_TX_FEEDER_STATS_EN
        ,
        .frame_words (frame_words),
        .frame_count (frame_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int done_cnt = 0;
    int since_done = 0;
    bit strobe_seen = 0;
    bit prev_strobe = 0;
    bit m_ovf = 0;
    logic [9:0] q[$];
    logic [9:0] log_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // coax_tx model: drops ready for WORD_CYC cycles per word, holds
    // active for TAIL cycles after the last word completes.
    initial begin
        int bcnt;
        int tcnt;
        bcnt = 0;
        tcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                bcnt = 0; tcnt = 0; rsp_ready = 1; tx_active = 0;
            end else if (strobe_seen) begin
                rsp_ready = 0; tx_active = 1; bcnt = WORD_CYC; tcnt = TAIL;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) rsp_ready = 1;
            end else if (tcnt > 0) begin
                tcnt--;
                if (tcnt == 0) tx_active = 0;
            end
        end
    end

    // Reference model and per-cycle compare.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                q.delete();
                m_ovf = 0; strobe_seen = 0; prev_strobe = 0; since_done = 0;
                chk("rst_strobe", tx_strobe, 0);
                chk("rst_busy", busy, 0);
                chk("rst_empty", empty, 1);
                chk("rst_done", done, 0);
                chk("rst_ovf", overflow, 0);
            end else begin
                strobe_seen = tx_strobe;
                if (tx_strobe) begin
                    chk("strobe_ready", tx_ready, 1);
                    chk("strobe_double", prev_strobe, 0);
                    if (q.size() == 0) begin
                        chk("strobe_extra", 1, 0);
                    end else begin
                        chk("strobe_data", tx_data, q.pop_front());
                    end
                    log_q.push_back(tx_data);
                    strobe_cnt++;
                    since_done++;
                end
                prev_strobe = tx_strobe;
                if (done) begin
                    done_cnt++;
                    chk("done_has_words", since_done > 0, 1);
                    chk("done_line_idle", tx_active, 0);
                    since_done = 0;
                end
                if (!busy) begin
                    chk("idle_level", level, q.size());
                    chk("idle_empty", empty, q.size() == 0);
                    chk("idle_full", full, q.size() == DEPTH);
                end
                chk("overflow", overflow, m_ovf);
                if (wr_strobe && q.size() >= DEPTH) m_ovf = 1;
                else if (clear_error) m_ovf = 0;
                if (wr_strobe && q.size() < DEPTH) q.push_back(wr_data);
            end
        end
    end

    task automatic wr(input logic [9:0] w);
        @(posedge clk); #1;
        wr_data = w; wr_strobe = 1;
        @(posedge clk); #1;
        wr_strobe = 0;
    endtask

    task automatic run_frame(input int blk, input bit app, input logic [9:0] appw,
                             output int nst, output int nd, output int lat,
                             output int gaps);
        int s0, d0;
        bit got_done, app_done;
        s0 = strobe_cnt; d0 = done_cnt;
        lat = -1; gaps = 0; got_done = 0; app_done = 0;
        @(posedge clk); #1;
        start = 1; ready_block = (blk > 0);
        for (int c = 1; c <= 200 && !got_done; c++) begin
            @(posedge clk); #1;
            start = 0; wr_strobe = 0;
            if (c == blk) ready_block = 0;
            if (app && !app_done && dut.state == WAIT_ACK) begin
                wr_data = appw; wr_strobe = 1; app_done = 1;
            end
            @(negedge clk); #2;
            if (blk > 0 && c == blk - 1) begin
                chk("hold_no_strobe", strobe_cnt - s0, 0);
                chk("hold_in_send", dut.state, SEND);
            end
            if (lat < 0 && strobe_cnt != s0) lat = c;
            if (done) got_done = 1;
            else if (!busy) gaps++;
        end
        if (!got_done) begin
            checks++; errors++;
            $display("FAIL frame_timeout got no done expected done");
        end
        repeat (6) @(negedge clk);
        #2;
        nst = strobe_cnt - s0;
        nd = done_cnt - d0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nst, nd, lat, gaps, d0, n;
        // Reset
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        @(negedge clk); #2;
        chk("reset_state", dut.state, IDLE);
        chk("reset_empty", empty, 1);
        chk("reset_level", level, 0);
        chk("reset_tx_strobe", tx_strobe, 0);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_ovf", overflow, 0);

        // Start on empty FIFO is ignored
        d0 = done_cnt;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        repeat (8) @(negedge clk);
        #2;
        chk("empty_start_idle", dut.state, IDLE);
        chk("empty_start_done", done_cnt - d0, 0);

        // Single word
        wr(10'b0101110101);
        run_frame(0, 0, '0, nst, nd, lat, gaps);
        chk("single_strobes", nst, 1);
        chk("single_done", nd, 1);
        chk("single_latency", lat, 2);
        chk("single_word", log_q[log_q.size()-1], 10'b0101110101);
        chk("single_idle", dut.state, IDLE);

        // Three-word frame, ready held off initially
        wr(10'b0101110101);
        wr(10'b1010001110);
        wr(10'b0000000001);
        @(negedge clk); #2;
        chk("three_level", level, 3);
        run_frame(5, 0, '0, nst, nd, lat, gaps);
        n = log_q.size();
        chk("three_strobes", nst, 3);
        chk("three_done", nd, 1);
        chk("three_no_gap", gaps, 0);
        chk("three_w0", log_q[n-3], 10'b0101110101);
        chk("three_w1", log_q[n-2], 10'b1010001110);
        chk("three_w2", log_q[n-1], 10'b0000000001);

        // Overflow with DEPTH=4
        wr(10'h001); wr(10'h002); wr(10'h003); wr(10'h004); wr(10'h3FF);
        @(negedge clk); #2;
        chk("ovf_full", full, 1);
        chk("ovf_level", level, 4);
        chk("ovf_flag", overflow, 1);
        run_frame(0, 0, '0, nst, nd, lat, gaps);
        n = log_q.size();
        chk("ovf_strobes", nst, 4);
        chk("ovf_last_word", log_q[n-1], 10'h004);
        chk("ovf_sticky", overflow, 1);
        @(posedge clk); #1 clear_error = 1;
        @(posedge clk); #1 clear_error = 0;
        @(negedge clk); #2;
        chk("ovf_cleared", overflow, 0);

        // Mid-frame append during WAIT_ACK of word 1
        wr(10'h155);
        wr(10'h2AA);
        run_frame(0, 1, 10'h0F0, nst, nd, lat, gaps);
        n = log_q.size();
        chk("append_strobes", nst, 3);
        chk("append_done", nd, 1);
        chk("append_w2", log_q[n-1], 10'h0F0);

        // Reset asserted mid-SEND
        wr(10'h155);
        wr(10'h2AA);
        @(posedge clk); #1 start = 1; ready_block = 1;
        @(posedge clk); #1 start = 0;
        for (int i = 0; i < 20 && dut.state != SEND; i++) begin
            @(negedge clk); #2;
        end
        chk("pre_rst_send", dut.state, SEND);
        ready_block = 0;
        #1 chk("pre_rst_strobe", tx_strobe, 1);
        reset_n = 0;
        #1;
        chk("mid_rst_strobe", tx_strobe, 0);
        chk("mid_rst_state", dut.state, IDLE);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_level", level, 0);
        d0 = done_cnt;
        @(posedge clk); #1;
        @(posedge clk); #1 reset_n = 1;
        repeat (8) @(negedge clk);
        #2;
        chk("mid_rst_no_done", done_cnt - d0, 0);

        // Two frames of 3 and 1 words
        wr(10'h011); wr(10'h022); wr(10'h033);
        run_frame(0, 0, '0, nst, nd, lat, gaps);
        chk("stats_f1_strobes", nst, 3);
        wr(10'h044);
        run_frame(0, 0, '0, nst, nd, lat, gaps);
        chk("stats_f2_strobes", nst, 1);
`ifdef COAX_TX_FEEDER_STATS_EN
        chk("stats_words", frame_words, 1);
        chk("stats_count", frame_count, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
